ball_engine: RTL

- Consumes the paddle y positions, each being the vertical centre of a paddle.
- Owns ball motion, wall and paddle collision, scoring and the serve/game state machine for the 640x480 Pong field.
- Produces the ball position and scores for the display/renderer stage.
- All motion is gated by an internal tick enable; everything runs on clk, with no derived clocks.

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/tick_gen.sv | 24 ++
 rtl/ball_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg: shared field geometry, ball FSM states and helpers.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pong_pkg;

   localparam int H_RES     = 640;
   localparam int V_RES     = 480;
   localparam int BALL_SIZE = 8;
   localparam int PAD_HALF  = 20;

   typedef logic [9:0] coord_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      PLAY       = 3'd2,
      POINT      = 3'd3,
      GAMEOVER   = 3'd4
   } ball_state_t;

   localparam coord_t BALL_X0 = coord_t'(H_RES / 2 - BALL_SIZE / 2);
   localparam coord_t BALL_Y0 = coord_t'(V_RES / 2 - BALL_SIZE / 2);

   // Additions only, in 11 bits, so paddles near the top edge cannot underflow.
   function automatic logic overlap(input coord_t by, input coord_t py);
      logic [10:0] b;
      logic [10:0] p;
      b = {1'b0, by};
      p = {1'b0, py};
      return (b + 11'(BALL_SIZE + PAD_HALF) > p) && (b < p + 11'(PAD_HALF));
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? v : v + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen: free-running prescaler, one-clk tick every 2^TICK_DIV clk.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_gen #(
   parameter int TICK_DIV = 18
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   logic [TICK_DIV-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= r_cnt + TICK_DIV'(1);
   end

   assign tick = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ball_engine: Pong ball motion, collisions, scoring and serve FSM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ball_engine
   import pong_pkg::*;
#(
   parameter int PAD_L_X     = 16,
   parameter int PAD_R_X     = 616,
   parameter int PAD_W       = 8,
   parameter int TICK_DIV    = 18,
   parameter int SERVE_DELAY = 64,
   parameter int WIN_SCORE   = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serve_n,
   input  logic [9:0] pad_l_y,
   input  logic [9:0] pad_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over,
   output logic       hit_pulse,
   output logic       point_pulse
);

   localparam int              c_sc_w    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [c_sc_w-1:0] c_sc_last = c_sc_w'(SERVE_DELAY - 1);
   localparam logic [3:0]      c_win     = 4'(WIN_SCORE);

   ball_state_t       r_state, w_state_nx;
   coord_t            r_ball_x, r_ball_y, w_x_nx, w_y_nx;
   logic              r_dir_x, r_dir_y, w_dir_x_nx, w_dir_y_nx;
   logic [3:0]        r_score_l, r_score_r, w_score_l_nx, w_score_r_nx, w_score_inc;
   logic [c_sc_w-1:0] r_serve_cnt, w_cnt_nx;
   logic              r_scorer_r, w_scorer_nx;
   logic              r_hit, r_point, r_game_over, w_hit_nx, w_point_nx;
   logic              r_serve_meta, r_serve_sync, r_serve_prev;
   logic              w_tick, w_serve_evt;
   logic              w_top, w_bot, w_hit_l, w_hit_r, w_miss_l, w_miss_r, w_dx, w_dy;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   // Idle-high reset so a held-released button does not look like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_serve_meta <= 1'b1;
         r_serve_sync <= 1'b1;
         r_serve_prev <= 1'b1;
      end else begin
         r_serve_meta <= serve_n;
         r_serve_sync <= r_serve_meta;
         r_serve_prev <= r_serve_sync;
      end
   end
   assign w_serve_evt = r_serve_prev & ~r_serve_sync;

   assign w_top    = ~r_dir_y && (r_ball_y == '0);
   assign w_bot    =  r_dir_y && ({1'b0, r_ball_y} + 11'(BALL_SIZE) == 11'(V_RES));
   assign w_hit_l  = ~r_dir_x && (r_ball_x == coord_t'(PAD_L_X + PAD_W)) && overlap(r_ball_y, pad_l_y);
   assign w_hit_r  =  r_dir_x && ({1'b0, r_ball_x} + 11'(BALL_SIZE) == 11'(PAD_R_X))
                              && overlap(r_ball_y, pad_r_y);
   assign w_miss_l = ~r_dir_x && (r_ball_x == '0);
   assign w_miss_r =  r_dir_x && ({1'b0, r_ball_x} + 11'(BALL_SIZE) == 11'(H_RES));
   assign w_dx     = w_hit_l | (r_dir_x & ~w_hit_r);
   assign w_dy     = w_top   | (r_dir_y & ~w_bot);
   assign w_score_inc = sat_inc(r_scorer_r ? r_score_r : r_score_l, c_win);

   always_comb begin
      w_state_nx   = r_state;
      w_x_nx       = r_ball_x;
      w_y_nx       = r_ball_y;
      w_dir_x_nx   = r_dir_x;
      w_dir_y_nx   = r_dir_y;
      w_score_l_nx = r_score_l;
      w_score_r_nx = r_score_r;
      w_cnt_nx     = r_serve_cnt;
      w_scorer_nx  = r_scorer_r;
      w_hit_nx     = 1'b0;
      w_point_nx   = 1'b0;
      case (r_state)
         IDLE: begin
            w_x_nx = BALL_X0;
            w_y_nx = BALL_Y0;
            if (w_serve_evt) begin
               w_state_nx = SERVE_WAIT;
               w_cnt_nx   = '0;
            end
         end
         SERVE_WAIT: begin
            if (w_tick) begin
               if (r_serve_cnt == c_sc_last) w_state_nx = PLAY;
               else                          w_cnt_nx   = r_serve_cnt + c_sc_w'(1);
            end
         end
         PLAY: begin
            if (w_tick) begin
               if (w_miss_l || w_miss_r) begin
                  w_state_nx  = POINT;
                  w_scorer_nx = w_miss_l;
               end else begin
                  w_dir_x_nx = w_dx;
                  w_dir_y_nx = w_dy;
                  w_x_nx     = w_dx ? r_ball_x + 10'd1 : r_ball_x - 10'd1;
                  w_y_nx     = w_dy ? r_ball_y + 10'd1 : r_ball_y - 10'd1;
                  w_hit_nx   = w_hit_l | w_hit_r;
               end
            end
         end
         POINT: begin
            w_point_nx = 1'b1;
            w_x_nx     = BALL_X0;
            w_y_nx     = BALL_Y0;
            // Next serve travels toward whoever just conceded.
            w_dir_x_nx = ~r_scorer_r;
            if (r_scorer_r) w_score_r_nx = w_score_inc;
            else            w_score_l_nx = w_score_inc;
            w_cnt_nx   = '0;
            w_state_nx = (w_score_inc == c_win) ? GAMEOVER : SERVE_WAIT;
         end
         GAMEOVER: begin
            w_x_nx = BALL_X0;
            w_y_nx = BALL_Y0;
            if (w_serve_evt) begin
               w_score_l_nx = '0;
               w_score_r_nx = '0;
               w_dir_x_nx   = 1'b1;
               w_cnt_nx     = '0;
               w_state_nx   = SERVE_WAIT;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ball_x    <= BALL_X0;
         r_ball_y    <= BALL_Y0;
         r_dir_x     <= 1'b1;
         r_dir_y     <= 1'b1;
         r_score_l   <= '0;
         r_score_r   <= '0;
         r_serve_cnt <= '0;
         r_scorer_r  <= 1'b0;
         r_hit       <= 1'b0;
         r_point     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_ball_x    <= w_x_nx;
         r_ball_y    <= w_y_nx;
         r_dir_x     <= w_dir_x_nx;
         r_dir_y     <= w_dir_y_nx;
         r_score_l   <= w_score_l_nx;
         r_score_r   <= w_score_r_nx;
         r_serve_cnt <= w_cnt_nx;
         r_scorer_r  <= w_scorer_nx;
         r_hit       <= w_hit_nx;
         r_point     <= w_point_nx;
         r_game_over <= (w_state_nx == GAMEOVER);
      end
   end

   assign ball_x      = r_ball_x;
   assign ball_y      = r_ball_y;
   assign score_l     = r_score_l;
   assign score_r     = r_score_r;
   assign game_over   = r_game_over;
   assign hit_pulse   = r_hit;
   assign point_pulse = r_point;

endmodule
`default_nettype wire
